// File: rtl/audio_pdm_receiver.sv
// Stereo PDM microphone receiver: generates the PDM bit clock, de-multiplexes
// left/right bits and decimates each channel with an order-2 CIC to 32-bit PCM.
module audio_pdm_receiver #(
  parameter int CKDIV    = 4,
  parameter int DEC_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic        ock,
  input  logic        sdi,
  output logic [31:0] dout_l,
  output logic [31:0] dout_r,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic        ovf
);

  // Integrator width covers the full CIC gain R^2 plus sign.
  localparam int IW = 2 * DEC_LOG2 + 2;
  localparam logic [7:0]          DIV_LAST = 8'(CKDIV - 1);
  localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;
  localparam logic [31:0]         PCM_MID  = 32'h8000_0000;

  typedef struct packed {
    logic [IW-1:0] i1;  // first integrator
    logic [IW-1:0] i2;  // second integrator
    logic [IW-1:0] z1;  // comb-1 delay (previous i2 at decimation)
    logic [IW-1:0] z2;  // comb-2 delay (previous comb-1 output)
  } cic_t;

  logic [7:0]          div_cnt;
  logic                sdi_s1, sdi_s2;
  logic [DEC_LOG2-1:0] bit_cnt;
  logic [1:0]          settle;
  logic                dec_stb;
  cic_t                ch_l, ch_r;

  logic                div_wrap, smp_l, smp_r, out_evt;
  logic [IW-1:0]       x, c1_l, c1_r, y_l, y_r;

  assign div_wrap = en && (div_cnt == DIV_LAST);
  assign smp_l    = div_wrap && ock;
  assign smp_r    = div_wrap && !ock;
  assign x        = sdi_s2 ? IW'(1) : {IW{1'b1}};

  assign c1_l = ch_l.i2 - ch_l.z1;
  assign c1_r = ch_r.i2 - ch_r.z1;
  assign y_l  = c1_l - ch_l.z2;
  assign y_r  = c1_r - ch_r.z2;

  assign out_evt = dec_stb && (settle == 2'd2);

  function automatic logic [31:0] to_pcm(input logic [IW-1:0] y);
    return PCM_MID + ({{(32 - IW){y[IW-1]}}, y} << (32 - IW));
  endfunction

  // NOTE: every register here uses <= so all flops see pre-edge values; a
  // blocking write would let i2 pick up the freshly updated i1 in the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      ock     <= 1'b0;
      bit_cnt <= '0;
      settle  <= '0;
      dec_stb <= 1'b0;
      ch_l    <= '0;
      ch_r    <= '0;
    end else if (!en) begin
      div_cnt <= '0;
      ock     <= 1'b0;
      bit_cnt <= '0;
      settle  <= '0;
      dec_stb <= 1'b0;
      ch_l    <= '0;
      ch_r    <= '0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        ock     <= ~ock;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (smp_l) begin
        ch_l.i1 <= ch_l.i1 + x;
        ch_l.i2 <= ch_l.i2 + ch_l.i1;
      end
      if (smp_r) begin
        ch_r.i1 <= ch_r.i1 + x;
        ch_r.i2 <= ch_r.i2 + ch_r.i1;
        bit_cnt <= bit_cnt + 1'b1;
      end

      dec_stb <= smp_r && (bit_cnt == CNT_LAST);

      if (dec_stb) begin
        ch_l.z1 <= ch_l.i2;
        ch_l.z2 <= c1_l;
        ch_r.z1 <= ch_r.i2;
        ch_r.z2 <= c1_r;
        if (settle != 2'd2) settle <= settle + 2'd1;
      end
    end
  end

  // Output stage holds its state while disabled; only reset clears ovf.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_l   <= PCM_MID;
      dout_r   <= PCM_MID;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (en) begin
      if (out_evt) begin
        dout_l   <= to_pcm(y_l);
        dout_r   <= to_pcm(y_r);
        dout_vld <= 1'b1;
        if (dout_vld && !dout_rdy) ovf <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/audio_pdm_receiver.md
AUDIO_PDM_RECEIVER -- requirements
Module: audio_pdm_receiver

Interface
REQ-001 SHALL have parameter CKDIV, default 4, clk cycles per ock half-period (legal range 2..255).
REQ-002 SHALL have parameter DEC_LOG2, default 6, log2 of decimation ratio R (R = 64 at default); only the default is verified.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge clk.
REQ-004 SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1 bit, receiver enable.
REQ-006 SHALL have port ock, output, 1 bit, PDM bit clock driven to the stereo PDM transmitter.
REQ-007 SHALL have port sdi, input, 1 bit, stereo PDM data (left and right time-multiplexed).
REQ-008 SHALL have port dout_l, output, 32 bits, left PCM sample, offset binary.
REQ-009 SHALL have port dout_r, output, 32 bits, right PCM sample, offset binary.
REQ-010 SHALL have port dout_vld, output, 1 bit, sample pair valid.
REQ-011 SHALL have port dout_rdy, input, 1 bit, consumer ready.
REQ-012 SHALL have port ovf, output, 1 bit, sticky overrun flag.

Function
REQ-013 SHALL register ock from a divider: ock toggles every CKDIV clk cycles while en=1; ock period = 2*CKDIV clk.
REQ-014 SHALL, while en=0, hold ock=0, clear the divider, integrators, combs, bit counter and settle counter, and hold dout_l, dout_r, dout_vld and ovf.
REQ-015 SHALL pass sdi through a 2-flop synchronizer; only the synchronized value is sampled.
REQ-016 SHALL sample the left bit on the last clk cycle of each ock-high phase and the right bit on the last clk cycle of each ock-low phase.
REQ-017 SHALL map each sampled bit to +1 when 1 and -1 when 0.
REQ-018 SHALL run an order-2 CIC decimator per channel: two cascaded 14-bit two's-complement integrators updated once per sample of that channel; wrap-around overflow is permitted and exact.
REQ-019 SHALL count right-channel samples; on the R-th, one clk later, decimate both channels through two cascaded 14-bit comb stages (differential delay 1), yielding y in [-4096, +4096].
REQ-020 SHALL form each output as 32'h80000000 + (sign-extended y << 18), modulo 2^32.
REQ-021 SHALL suppress the first 2 decimation results after reset or after en rises (CIC settling); from the 3rd onward a result is an output event.
REQ-022 SHALL, on an output event, load dout_l/dout_r and set dout_vld=1 in the same cycle; latency from the R-th right sample to dout_vld = 2 clk.
REQ-023 SHALL clear dout_vld on any cycle with dout_vld=1 and dout_rdy=1 with no output event; an output event on that cycle keeps dout_vld=1 with new data.
REQ-024 SHALL, on an output event while dout_vld=1 and dout_rdy=0, overwrite dout_l/dout_r and set ovf=1.
REQ-025 SHALL keep ovf set until reset; en does not clear it.
REQ-026 SHALL hold dout_l/dout_r stable while dout_vld=1 and no output event occurs.

Reset
REQ-027 SHALL, on rstn=0, asynchronously set ock=0, dout_l=dout_r=32'h80000000, dout_vld=0, ovf=0, and clear the divider, synchronizer, integrators, combs and counters.
REQ-028 SHALL, after rstn deasserts with en=1, start ock low for CKDIV clk; reset mid-frame discards the partial frame.

Verification
REQ-029 SHALL verify: en=1, sdi=1 constant, dout_rdy=1 -> 3rd decimation onward dout_l=dout_r=32'hC0000000, dout_vld pulses once every 512 clk, ovf=0.
REQ-030 SHALL verify: sdi=0 constant -> dout_l=dout_r=32'h40000000.
REQ-031 SHALL verify: sdi=1 during ock-high phases and 0 during ock-low phases (after sync delay) -> dout_l=32'hC0000000, dout_r=32'h40000000.
REQ-032 SHALL verify: left bits alternate 1,0,1,0..., right constant 1 -> dout_l=32'h80000000, dout_r=32'hC0000000.
REQ-033 SHALL verify: dout_rdy=0 across two output events -> dout_vld stays 1, ovf=1, data = latest pair; dout_rdy=1 for one cycle -> dout_vld=0.
REQ-034 SHALL verify: rstn pulsed low mid-frame, and separately en dropped for 10 clk -> ock=0 during the pulse/drop, first dout_vld only after the 3rd full decimation period following the pulse/drop.
